// File: rtl/z80_busrq_arbiter.sv
// Round-robin arbiter that hands the Z80 bus to one of two DMA masters via nBUSRQ/nBUSACK.
// Define Z80_ARB_TIMEOUT_EN to add a hold-time limit of MAX_HOLD grant cycles.
module z80_busrq_arbiter #(
  parameter int MAX_HOLD = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       nBUSACK,
  output logic       nBUSRQ,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_GRANT,
    S_RELEASE
  } state_e;

  state_e state_q, state_d;
  logic   ack_meta_q, ack_sync_q;
  logic   ack;
  logic   owner_q, owner_d;
  logic   last_q, last_d;

`ifdef Z80_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
  logic       hold_fire;

  // Last permitted grant cycle: the counter reads 0 on the first GRANT cycle.
  assign hold_fire   = (hold_q == 8'(MAX_HOLD - 1));
  assign timeout_err = timeout_q;
`else
  logic unused_max_hold;

  // MAX_HOLD only matters when the hold limit is built in.
  assign unused_max_hold = ^8'(MAX_HOLD);
  assign timeout_err     = 1'b0;
`endif

  assign ack = ~ack_sync_q;

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; blocking here would make the result depend on statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ack_meta_q <= 1'b1;
      ack_sync_q <= 1'b1;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
`ifdef Z80_ARB_TIMEOUT_EN
      hold_q     <= 8'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ack_meta_q <= nBUSACK;
      ack_sync_q <= ack_meta_q;
      owner_q    <= owner_d;
      last_q     <= last_d;
`ifdef Z80_ARB_TIMEOUT_EN
      hold_q     <= hold_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef Z80_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          // On a tie the requester not served last wins.
          owner_d = (req == 2'b11) ? ~last_q : req[1];
          state_d = S_REQUEST;
        end
      end
      S_REQUEST: begin
`ifdef Z80_ARB_TIMEOUT_EN
        hold_d = 8'd0;
`endif
        if (ack) begin
          state_d = req[owner_q] ? S_GRANT : S_RELEASE;
        end
      end
      S_GRANT: begin
`ifdef Z80_ARB_TIMEOUT_EN
        hold_d = hold_q + 8'd1;
`endif
        if (!ack || !req[owner_q]) begin
          state_d = S_RELEASE;
        end
`ifdef Z80_ARB_TIMEOUT_EN
        else if (hold_fire) begin
          state_d   = S_RELEASE;
          timeout_d = 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        if (!ack) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the state alone, so an async reset clears them immediately.
  always_comb begin
    nBUSRQ = 1'b1;
    grant  = 2'b00;
    busy   = (state_q != S_IDLE);
    case (state_q)
      S_REQUEST: nBUSRQ = 1'b0;
      S_GRANT: begin
        nBUSRQ = 1'b0;
        grant  = owner_q ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_z80_busrq_arbiter.sv
// Randomized scoreboard bench for z80_busrq_arbiter with a Z80 bus-acknowledge model
// and a transaction-level round-robin reference model.
module tb_z80_busrq_arbiter;

  localparam int MAX_HOLD  = 16;
  localparam int K_NORMAL  = 0;
  localparam int K_ABORT   = 1;
  localparam int K_ACKDROP = 2;
  localparam int K_RESET   = 3;
  localparam int K_LONG    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic       nBUSACK;
  logic       nBUSRQ;
  logic [1:0] grant;
  logic       busy;
  logic       timeout_err;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned ack_fall_cyc = 0;
  int          ack_dly = 4;
  bit          z80_kill = 1'b0;
  bit          z80_rst = 1'b0;
  logic        model_last;
  logic [1:0]  exp_q[$];
  logic [1:0]  prev_grant = 2'b00;

  z80_busrq_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .nBUSACK    (nBUSACK),
    .nBUSRQ     (nBUSRQ),
    .grant      (grant),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Z80 model: nBUSACK follows nBUSRQ after ack_dly clocks; kill/reset force it high.
  initial begin
    int cnt;
    cnt = 0;
    nBUSACK = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (z80_rst || z80_kill) begin
        nBUSACK = 1'b1;
        cnt = 0;
      end else if (nBUSACK != nBUSRQ) begin
        cnt++;
        if (cnt >= ack_dly) begin
          nBUSACK = nBUSRQ;
          cnt = 0;
          if (!nBUSACK) ack_fall_cyc = cyc;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops the expected owner on each grant rise and checks standing invariants.
  always @(negedge clk) begin
    if (!reset) begin
      if (grant !== 2'b00 && prev_grant === 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(grant), 32'd0);
        end else begin
          check("grant_owner", 32'(grant), 32'(exp_q.pop_front()));
          check("ack_to_grant", 32'(cyc - ack_fall_cyc), 32'd3);
        end
      end
      check("invariants", 32'((grant !== 2'b11)
                              && (grant === 2'b00 || (nBUSRQ === 1'b0 && busy === 1'b1))
                              && (busy === 1'b1 || (nBUSRQ === 1'b1 && grant === 2'b00))
`ifndef Z80_ARB_TIMEOUT_EN
                              && (timeout_err === 1'b0)
`endif
                              ), 32'd1);
    end
    prev_grant <= grant;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // One bus tenure, started from IDLE; expected owner comes from the round-robin rule.
  task automatic tenure(input int kind, input logic [1:0] force_pat, input bit keep, input int dly);
    logic [1:0] pat;
    logic [1:0] egr;
    logic       own;
    int         n;
    int         p;
    bit         bad;
    @(negedge clk);
    wait_idle();
    if (req == 2'b00) begin
      pat = (force_pat != 2'b00) ? force_pat : 2'($urandom_range(1, 3));
      req = pat;
    end else begin
      pat = req;
    end
    own = (pat == 2'b11) ? ~model_last : pat[1];
    model_last = own;
    egr = own ? 2'b10 : 2'b01;
    if (dly != 0) ack_dly = dly;
    else if (kind == K_ABORT) ack_dly = $urandom_range(3, 6);
    else ack_dly = $urandom_range(1, 6);
    if (kind != K_ABORT) exp_q.push_back(egr);
    @(negedge clk);
    check("busrq_latency", 32'(nBUSRQ), 32'd0);
    check("busy_active", 32'(busy), 32'd1);

    if (kind == K_ABORT) begin
      @(negedge clk);
      req = 2'b00;
      n = 0;
      while (nBUSRQ !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("abort_busrq_release", 32'(nBUSRQ), 32'd1);
      check("abort_held_until_ack", 32'(nBUSACK), 32'd0);
      return;
    end

    n = 0;
    while (grant === 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (grant === 2'b00) begin
      check("grant_timeout", 32'(grant), 32'(egr));
      exp_q.delete();
      req = 2'b00;
      return;
    end

    case (kind)
      K_RESET: begin
        #2;
        reset = 1'b1;
        z80_rst = 1'b1;
        #1;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_busrq", 32'(nBUSRQ), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_timeout_err", 32'(timeout_err), 32'd0);
        model_last = 1'b1;
        exp_q.delete();
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        z80_rst = 1'b0;
      end
      K_ACKDROP: begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        z80_kill = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (grant !== 2'b00 && n < 10);
        check("ackdrop_latency", 32'(n), 32'd4);
        check("ackdrop_busy", 32'(busy), 32'd1);
        check("ackdrop_busrq", 32'(nBUSRQ), 32'd1);
        req = 2'b00;
        @(negedge clk);
        check("ackdrop_idle", 32'(busy), 32'd0);
        z80_kill = 1'b0;
      end
      K_LONG: begin
`ifdef Z80_ARB_TIMEOUT_EN
        n = 0;
        while (grant !== 2'b00 && n < 400) begin
          n++;
          @(negedge clk);
        end
        check("hold_cycles", 32'(n), 32'(MAX_HOLD));
        req = 2'b00;
        p = 0;
        for (int i = 0; i < 10; i++) begin
          if (timeout_err === 1'b1) p++;
          @(negedge clk);
        end
        check("timeout_pulses", 32'(p), 32'd1);
`else
        bad = 1'b0;
        p = 0;
        repeat (1000) begin
          @(negedge clk);
          if (grant !== egr) bad = 1'b1;
          if (timeout_err !== 1'b0) p++;
        end
        check("hold_1000", 32'(bad), 32'd0);
        check("no_timeout_err", 32'(p), 32'd0);
        req = 2'b00;
        @(negedge clk);
        check("long_release", 32'(grant), 32'd0);
`endif
      end
      default: begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
        req = keep ? (pat & ~egr) : 2'b00;
        @(negedge clk);
        check("release_grant", 32'(grant), 32'd0);
        check("release_busrq", 32'(nBUSRQ), 32'd1);
        check("release_busy", 32'(busy), 32'd1);
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    reset = 1'b0;
    req = 2'b00;
    model_last = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check("por_busrq", 32'(nBUSRQ), 32'd1);
    check("por_grant", 32'(grant), 32'd0);
    check("por_busy", 32'(busy), 32'd0);
    check("por_timeout_err", 32'(timeout_err), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    tenure(K_NORMAL, 2'b01, 1'b0, 4);
    repeat (3) begin
      tenure(K_NORMAL, 2'b11, 1'b1, 0);
      tenure(K_NORMAL, 2'b00, 1'b0, 0);
    end
    tenure(K_ABORT, 2'b01, 1'b0, 0);
    tenure(K_ACKDROP, 2'b00, 1'b0, 0);
    tenure(K_RESET, 2'b10, 1'b0, 0);
    tenure(K_NORMAL, 2'b11, 1'b0, 0);
    tenure(K_LONG, 2'b01, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      tenure(kind, 2'b00, 1'($urandom_range(0, 1)), 0);
    end

    @(negedge clk);
    wait_idle();
    req = 2'b00;
    repeat (10) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
